// File: rtl/add32_arb_seq_if.sv
// Requester/response bundle for add32_arb_seq: two operand ports and one result port.
// The DUT uses the slave modport; the environment driving requests uses master.
interface add32_arb_seq_if;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_cin, req1_cin;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_s;
   logic        rsp_cout, rsp_id;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_s, rsp_cout, rsp_id,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_s, rsp_cout, rsp_id,
      output rsp_ready
   );
endinterface

// File: rtl/add32_arb_seq.sv
// Two-requester 32-bit adder sharing one 8-bit ripple slice over four beats.
// Round-robin tie break; the result is held in RESP until the consumer takes it.
module add32_arb_seq #(
   parameter bit FIRST_GRANT = 1'b0
) (
   input logic           clk,
   input logic           rst_n,
   add32_arb_seq_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
   } req_t;

   logic [1:0]  state;
   logic [1:0]  beat;
   logic        cry;
   logic        prio;
   logic [31:0] a_q, b_q, s_q;
   logic        cout_q, id_q;

   logic        gnt, rdy0, rdy1, acc;
   req_t        sel;
   logic [4:0]  idx;
   logic [8:0]  slice;

   // Tie goes to the pointer; a lone valid requester always wins.
   assign gnt  = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
   assign rdy0 = (state == IDLE) && bus.req0_valid && !gnt;
   assign rdy1 = (state == IDLE) && bus.req1_valid && gnt;
   assign acc  = rdy0 || rdy1;

   assign sel = gnt ? '{a: bus.req1_a, b: bus.req1_b, cin: bus.req1_cin}
                    : '{a: bus.req0_a, b: bus.req0_b, cin: bus.req0_cin};

   assign idx   = {beat, 3'b000};
   assign slice = {1'b0, a_q[idx +: 8]} + {1'b0, b_q[idx +: 8]} + {8'd0, cry};

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_s      = s_q;
   assign bus.rsp_cout   = cout_q;
   assign bus.rsp_id     = id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         beat   <= 2'd0;
         cry    <= 1'b0;
         prio   <= FIRST_GRANT;
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         cout_q <= 1'b0;
         id_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (acc) begin
                  a_q    <= sel.a;
                  b_q    <= sel.b;
                  cry    <= sel.cin;
                  id_q   <= gnt;
                  prio   <= ~gnt;
                  beat   <= 2'd0;
                  s_q    <= '0;
                  cout_q <= 1'b0;
                  state  <= CALC;
               end
            end
            CALC: begin
               s_q[idx +: 8] <= slice[7:0];
               cry           <= slice[8];
               beat          <= beat + 2'd1;
               if (beat == 2'd3) begin
                  cout_q <= slice[8];
                  state  <= RESP;
               end
            end
            RESP: begin
               // Leaving RESP lands in IDLE; acceptance waits for the next edge.
               if (bus.rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add32_arb_seq.sv
// Self-checking bench for add32_arb_seq: directed scenarios plus randomized
// traffic against a plain-arithmetic model with a round-robin pointer.
module tb_add32_arb_seq;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   add32_arb_seq_if bus();

   add32_arb_seq #(.FIRST_GRANT(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   bit mprio = 1'b0;

   function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b, input bit c);
      return {1'b0, a} + {1'b0, b} + {32'd0, c};
   endfunction

   function automatic bit ref_grant(input bit v0, input bit v1, input bit p);
      if (v0 && v1) return p;
      return v1;
   endfunction

   // Drives one request, waits for acceptance and response, and reports what it saw.
   task automatic issue(input bit v0, input bit v1,
                        input logic [31:0] a0, input logic [31:0] b0, input bit c0,
                        input logic [31:0] a1, input logic [31:0] b1, input bit c1,
                        input int hold,
                        output int port, output int waitn, output int lat,
                        output logic [31:0] s, output logic cout, output logic id,
                        output bit busy_rdy, output bit unstable, output bit dropped, output bit tmo);
      tmo = 0; busy_rdy = 0; unstable = 0; dropped = 0;
      port = -1; waitn = 0; lat = 0; s = '0; cout = 0; id = 0;
      @(negedge clk);
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_cin = c0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_cin = c1;
      bus.rsp_ready  = 1'b0;
      for (int i = 0; i < 20 && port < 0; i++) begin
         #1;
         if (bus.req0_ready && v0) port = 0;
         else if (bus.req1_ready && v1) port = 1;
         else begin waitn++; @(negedge clk); end
      end
      if (port < 0) begin tmo = 1; return; end
      @(posedge clk); #1;
      // Scramble operands while busy; the in-flight result must not change.
      bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_cin = 1'($urandom);
      bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_cin = 1'($urandom);
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         if (bus.req0_ready || bus.req1_ready) busy_rdy = 1;
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.rsp_valid) begin tmo = 1; return; end
      s = bus.rsp_s; cout = bus.rsp_cout; id = bus.rsp_id;
      if (bus.req0_ready || bus.req1_ready) busy_rdy = 1;
      repeat (hold) begin
         @(posedge clk); #1;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_s !== s || bus.rsp_cout !== cout || bus.rsp_id !== id)
            unstable = 1;
         if (bus.req0_ready || bus.req1_ready) busy_rdy = 1;
      end
      @(negedge clk); bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      dropped = (bus.rsp_valid === 1'b0);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
      bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0;
      bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.rsp_valid); end
      total++; if (bus.rsp_s !== 32'd0) begin bad++; $display("FAIL reset_s got=%h want=0", bus.rsp_s); end
      total++; if (bus.rsp_cout !== 1'b0 || bus.rsp_id !== 1'b0)
         begin bad++; $display("FAIL reset_cout_id got=%b%b want=00", bus.rsp_cout, bus.rsp_id); end
      total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
         begin bad++; $display("FAIL reset_ready got=%b%b want=00", bus.req0_ready, bus.req1_ready); end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      mprio = 1'b0;
   endtask

   task automatic test_basic();
      int port, waitn, lat; logic [31:0] s; logic cout, id; bit br, un, dr, tmo;
      issue(1, 0, 32'h000000FF, 32'h00000001, 0, 0, 0, 0, 0, port, waitn, lat, s, cout, id, br, un, dr, tmo);
      total++; if (tmo || port !== 0 || waitn !== 0)
         begin bad++; $display("FAIL basic_accept port=%0d wait=%0d tmo=%0d want port=0 wait=0", port, waitn, tmo); end
      total++; if (lat !== 5) begin bad++; $display("FAIL basic_latency got=%0d want=5", lat); end
      total++; if (s !== 32'h00000100 || cout !== 1'b0 || id !== 1'b0)
         begin bad++; $display("FAIL basic_result got s=%h c=%b id=%b want s=00000100 c=0 id=0", s, cout, id); end
      total++; if (br || !dr) begin bad++; $display("FAIL basic_handshake busy_ready=%0d dropped=%0d want 0/1", br, dr); end
      mprio = 1'b1;
   endtask

   task automatic test_carry();
      int port, waitn, lat; logic [31:0] s; logic cout, id; bit br, un, dr, tmo;
      issue(0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'h00000000, 1, 0, port, waitn, lat, s, cout, id, br, un, dr, tmo);
      total++; if (tmo || port !== 1) begin bad++; $display("FAIL carry_accept port=%0d tmo=%0d want 1", port, tmo); end
      total++; if (s !== 32'h00000000 || cout !== 1'b1 || id !== 1'b1)
         begin bad++; $display("FAIL carry_result got s=%h c=%b id=%b want s=00000000 c=1 id=1", s, cout, id); end
      mprio = 1'b0;
   endtask

   task automatic test_tie();
      int port, waitn, lat; logic [31:0] s; logic cout, id; bit br, un, dr, tmo;
      logic [31:0] a0, b0, a1, b1; bit c0, c1; logic [32:0] e;
      for (int n = 0; n < 4; n++) begin
         a0 = $urandom; b0 = $urandom; c0 = 1'($urandom);
         a1 = $urandom; b1 = $urandom; c1 = 1'($urandom);
         issue(1, 1, a0, b0, c0, a1, b1, c1, 0, port, waitn, lat, s, cout, id, br, un, dr, tmo);
         e = (n % 2 == 0) ? ref_sum(a0, b0, c0) : ref_sum(a1, b1, c1);
         total++; if (tmo || id !== 1'(n % 2) || port !== n % 2)
            begin bad++; $display("FAIL tie_id op=%0d got id=%b port=%0d want=%0d", n, id, port, n % 2); end
         total++; if ({cout, s} !== e)
            begin bad++; $display("FAIL tie_sum op=%0d got=%h want=%h", n, {cout, s}, e); end
         if (n > 0) begin
            total++; if (waitn !== 0 || lat !== 5)
               begin bad++; $display("FAIL tie_period op=%0d wait=%0d lat=%0d want 0/5", n, waitn, lat); end
         end
      end
      mprio = 1'b0;
   endtask

   task automatic test_backpressure();
      int port, waitn, lat; logic [31:0] s; logic cout, id; bit br, un, dr, tmo;
      logic [31:0] a0, b0, a1, b1; logic [32:0] e; bit g;
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      g = ref_grant(1, 1, mprio);
      issue(1, 1, a0, b0, 1, a1, b1, 0, 10, port, waitn, lat, s, cout, id, br, un, dr, tmo);
      e = g ? ref_sum(a1, b1, 0) : ref_sum(a0, b0, 1);
      total++; if (tmo || port !== int'(g) || {cout, s} !== e)
         begin bad++; $display("FAIL bp_result got port=%0d sum=%h want port=%0d sum=%h", port, {cout, s}, g, e); end
      total++; if (un) begin bad++; $display("FAIL bp_stable got unstable=1 want 0"); end
      total++; if (br) begin bad++; $display("FAIL bp_ready got busy_ready=1 want 0"); end
      total++; if (!dr) begin bad++; $display("FAIL bp_take got rsp_valid still high want low"); end
      mprio = ~g;
   endtask

   task automatic test_single();
      int port, waitn, lat; logic [31:0] s; logic cout, id; bit br, un, dr, tmo;
      logic [31:0] a1, b1; logic [32:0] e;
      issue(1, 0, 32'h1, 32'h2, 0, 0, 0, 0, 0, port, waitn, lat, s, cout, id, br, un, dr, tmo);
      mprio = 1'b1;
      for (int n = 0; n < 2; n++) begin
         a1 = $urandom; b1 = $urandom;
         issue(0, 1, 0, 0, 0, a1, b1, 1, 0, port, waitn, lat, s, cout, id, br, un, dr, tmo);
         e = ref_sum(a1, b1, 1);
         total++; if (tmo || port !== 1 || id !== 1'b1 || waitn !== 0)
            begin bad++; $display("FAIL single_grant ptr=%b got port=%0d id=%b wait=%0d want 1", mprio, port, id, waitn); end
         total++; if ({cout, s} !== e) begin bad++; $display("FAIL single_sum got=%h want=%h", {cout, s}, e); end
         mprio = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      int port, waitn, lat; logic [31:0] s; logic cout, id; bit br, un, dr, tmo; bit seen;
      @(negedge clk);
      bus.req0_valid = 1; bus.req0_a = 32'h01010101; bus.req0_b = 32'h01010101; bus.req0_cin = 0;
      bus.req1_valid = 0;
      @(posedge clk);
      #1 bus.req0_valid = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      total++; if (bus.rsp_valid !== 0 || bus.rsp_s !== 0 || bus.rsp_cout !== 0 || bus.rsp_id !== 0)
         begin bad++; $display("FAIL midrst_out got v=%b s=%h c=%b id=%b want all 0", bus.rsp_valid, bus.rsp_s, bus.rsp_cout, bus.rsp_id); end
      seen = 0;
      repeat (3) begin @(posedge clk); #1; if (bus.rsp_valid !== 1'b0) seen = 1; end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (bus.rsp_valid !== 1'b0) seen = 1; end
      total++; if (seen) begin bad++; $display("FAIL midrst_norsp got rsp_valid=1 want 0"); end
      mprio = 1'b0;
      #2 rst_n = 1'b0;
      #3;
      @(posedge clk);
      #2 rst_n = 1'b1;
      issue(1, 1, 32'h12345678, 32'h11111111, 0, 32'hDEADBEEF, 32'h1, 0, 0,
            port, waitn, lat, s, cout, id, br, un, dr, tmo);
      total++; if (tmo || port !== 0 || waitn !== 0)
         begin bad++; $display("FAIL midrst_first got port=%0d wait=%0d want port=0 wait=0", port, waitn); end
      total++; if (s !== 32'h23456789 || cout !== 1'b0 || lat !== 5)
         begin bad++; $display("FAIL midrst_sum got s=%h c=%b lat=%0d want 23456789/0/5", s, cout, lat); end
      mprio = 1'b1;
   endtask

   task automatic test_random();
      int port, waitn, lat; logic [31:0] s; logic cout, id; bit br, un, dr, tmo;
      logic [31:0] a0, b0, a1, b1; bit c0, c1, v0, v1, g; logic [32:0] e; int hold;
      for (int n = 0; n < 24; n++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         a0 = (n % 5 == 0) ? 32'hFFFFFFFF : $urandom; b0 = $urandom; c0 = 1'($urandom);
         a1 = $urandom; b1 = (n % 7 == 0) ? 32'hFFFFFFFF : $urandom; c1 = 1'($urandom);
         hold = $urandom_range(0, 3);
         g = ref_grant(v0, v1, mprio);
         issue(v0, v1, a0, b0, c0, a1, b1, c1, hold, port, waitn, lat, s, cout, id, br, un, dr, tmo);
         e = g ? ref_sum(a1, b1, c1) : ref_sum(a0, b0, c0);
         total++;
         if (tmo || port !== int'(g) || id !== g || {cout, s} !== e || lat !== 5 || br || un || !dr) begin
            bad++;
            $display("FAIL rand op=%0d got port=%0d id=%b sum=%h lat=%0d br=%0d un=%0d dr=%0d tmo=%0d want port=%0d sum=%h lat=5",
                     n, port, id, {cout, s}, lat, br, un, dr, tmo, g, e);
         end
         mprio = ~g;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_tie();
      test_backpressure();
      test_single();
      test_reset_mid();
      test_random();
      @(negedge clk);
      bus.req0_valid = 0; bus.req1_valid = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/add32_arb_seq.md
ADD32_ARB_SEQ -- requirements
Module: add32_arb_seq

Interface
REQ-001 The block SHALL provide parameter FIRST_GRANT, default 0, naming the requester that wins a tie on the first arbitration after reset.
REQ-002 The block SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL provide port rst_n  input  1  asynchronous reset, active-low.
REQ-004 The block SHALL provide ports req0_valid / req1_valid  input  1  requester operand valid.
REQ-005 The block SHALL provide ports req0_ready / req1_ready  output  1  requester operand accepted this cycle when high together with valid.
REQ-006 The block SHALL provide ports req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-007 The block SHALL provide ports req0_cin / req1_cin  input  1  carry-in.
REQ-008 The block SHALL provide port rsp_valid  output  1  result valid.
REQ-009 The block SHALL provide port rsp_ready  input  1  consumer accepts result.
REQ-010 The block SHALL provide ports rsp_s  output  32  sum; rsp_cout  output  1  carry-out; rsp_id  output  1  index of the served requester.

Function
REQ-011 The block SHALL share one 8-bit ripple-carry adder slice between two requesters, computing each 32-bit sum in four sequential 8-bit beats.
REQ-012 The FSM SHALL have states IDLE, CALC and RESP, with a 2-bit beat counter active in CALC.
REQ-013 In IDLE, the grant SHALL go to the only valid requester, or to the port named by the priority pointer when both requesters are valid.
REQ-014 reqN_ready SHALL be high only in IDLE and only for the granted port; a combinational valid-to-ready path is permitted; both readys SHALL be low in CALC and RESP.
REQ-015 On acceptance (valid && ready), the block SHALL register a, b and cin, set rsp_id to the granted port, set the priority pointer to the other port, clear the beat counter, and move to CALC.
REQ-016 Each CALC cycle with beat k SHALL compute bits [8k+7:8k] = a[8k+7:8k] + b[8k+7:8k] + carry register, where the carry register is loaded with cin at acceptance and updated with each slice carry-out.
REQ-017 After beat 3, rsp_cout SHALL equal the final slice carry-out and the FSM SHALL move to RESP.
REQ-018 Latency: rsp_valid SHALL rise exactly 5 rising edges after the acceptance edge, i.e. the acceptance edge plus 4 beat edges.
REQ-019 In RESP, rsp_valid SHALL be 1, and rsp_s, rsp_cout and rsp_id SHALL be held stable until rsp_ready is sampled high.
REQ-020 On the rsp_valid && rsp_ready edge, the FSM SHALL return to IDLE and rsp_valid SHALL fall; no new request SHALL be accepted in that same cycle.
REQ-021 Minimum request-to-request period SHALL be 6 cycles.
REQ-022 Requester input changes while the block is not in IDLE SHALL have no effect on an operation in progress.
REQ-023 Arithmetic SHALL be modulo 2^32, with the overflow bit reported only through rsp_cout; there SHALL be no signed interpretation.
REQ-024 A single persistently valid requester SHALL be granted on every IDLE visit regardless of the priority pointer.
REQ-025 The priority pointer SHALL change only on acceptance.

Reset
REQ-026 While rst_n is low, the block SHALL immediately be in IDLE with rsp_valid=0, rsp_s=0, rsp_cout=0, rsp_id=0, beat=0, carry register=0, and the priority pointer equal to FIRST_GRANT.
REQ-027 Reset asserted mid-CALC or mid-RESP SHALL abort the operation with no response ever issued for it.
REQ-028 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 Basic add: req0 with a=0x000000FF, b=0x00000001, cin=0 -> rsp_valid 5 edges after acceptance, rsp_s=0x00000100, rsp_cout=0, rsp_id=0.
REQ-030 Full carry chain: req1 with a=0xFFFFFFFF, b=0x00000000, cin=1 -> rsp_s=0x00000000, rsp_cout=1, rsp_id=1.
REQ-031 Tie arbitration, FIRST_GRANT=0: both requesters held valid for 4 operations with rsp_ready=1 -> rsp_id sequence 0,1,0,1, with each response carrying its own requester's sum.
REQ-032 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_s, rsp_cout and rsp_id stay constant, both readys stay 0, and the result is taken on the first rsp_ready=1 edge.
REQ-033 Reset during CALC beat 2 -> all outputs 0 immediately and no response issued; a subsequent req0 with a=0x12345678, b=0x11111111, cin=0 returns rsp_s=0x23456789, rsp_cout=0.
REQ-034 Single requester: only req1 is valid, with priority pointer=1 and then 0 -> req1 is accepted on every IDLE visit.
